// File: rtl/uart_pkg.sv
// Shared definitions for the sample packetizer.
//   SYNC_BYTE   : first byte of every frame
//   pkt_state_e : byte-sequencer state encoding
//   word_byte() : selects the high or low byte of a 16-bit sample word
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        LEN     = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CSUM    = 3'd5
    } pkt_state_e;

    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
        logic [7:0] b;
        if (hi) begin
            b = w[15:8];
        end else begin
            b = w[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/sample_packetizer_if.sv
// Handshake bundle between the sample source / UART transmitter and the
// packetizer.
//   in_data/in_valid/in_ready : sample word push handshake
//   flush                     : request to send a partial frame
//   tx_data/tx_new_data       : byte and one-cycle strobe to the UART
//   tx_busy                   : UART transmitter busy
//   busy/frame_done           : frame status
// master = environment side, slave = packetizer side.
interface sample_packetizer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [7:0]  tx_data;
    logic        tx_new_data;
    logic        tx_busy;
    logic        busy;
    logic        frame_done;

    modport master (
        output in_data, in_valid, flush, tx_busy,
        input  in_ready, tx_data, tx_new_data, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid, flush, tx_busy,
        output in_ready, tx_data, tx_new_data, busy, frame_done
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push_i   : write data_i (ignored when full unless popping the same cycle)
//   pop_i    : drop the head entry (ignored when empty)
//   data_o   : current head entry
//   count_o  : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok_s = push_i && ((count_q != DEPTH_C) || pop_ok_s);
    assign pop_ok_s  = pop_i && (count_q != {CW{1'b0}});
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap explicitly so any DEPTH works, and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= (wr_ptr_q == LAST_C) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= (rd_ptr_q == LAST_C) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/sample_packetizer.sv
// Buffers 16-bit samples and sends them to a byte UART as framed packets:
//   0xA5, N, {hi, lo} x N, XOR(N, payload bytes)
// A frame starts when FRAME_LEN words are buffered, or on flush with a
// partially filled FIFO. Every byte is strobed only when the UART is idle,
// and the sequencer waits to see tx_busy rise and fall before moving on.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sample_packetizer_if.slave (sample input, UART side, status)
module sample_packetizer
    import uart_pkg::*;
#(
    parameter int FRAME_LEN  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    sample_packetizer_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0] count_s;
    logic [15:0]   head_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    byte_s;
    pkt_state_e    next_state_s;

    pkt_state_e    state_q;
    logic [7:0]    tx_data_q;
    logic          tx_new_data_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          wait_q;   // set on issue, cleared once tx_busy is seen high
    logic          sent_q;   // byte of the current state already issued
    logic [7:0]    csum_q;
    logic [3:0]    n_q;
    logic [3:0]    rem_q;    // words not yet popped in this frame

    assign bus.in_ready    = (count_s < CW'(FIFO_DEPTH));
    assign push_s          = bus.in_valid && bus.in_ready;
    // The head word leaves in the cycle its low byte is on the strobe.
    assign pop_s           = tx_new_data_q && (state_q == DATA_LO);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_new_data = tx_new_data_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (bus.in_data),
        .data_o  (head_s),
        .count_o (count_s)
    );

    // Byte to send in the current state.
    always_comb begin
        byte_s = 8'h00;
        case (state_q)
            HDR:     byte_s = SYNC_BYTE;
            LEN:     byte_s = {4'h0, n_q};
            DATA_HI: byte_s = word_byte(head_s, 1'b1);
            DATA_LO: byte_s = word_byte(head_s, 1'b0);
            CSUM:    byte_s = csum_q;
            default: byte_s = 8'h00;
        endcase
    end

    // State following a completed byte.
    always_comb begin
        next_state_s = IDLE;
        case (state_q)
            HDR:     next_state_s = LEN;
            LEN:     next_state_s = DATA_HI;
            DATA_HI: next_state_s = DATA_LO;
            DATA_LO: next_state_s = (rem_q != 4'd0) ? DATA_HI : CSUM;
            CSUM:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Frame sequencer with registered UART strobe and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'h00;
            tx_new_data_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            wait_q        <= 1'b0;
            sent_q        <= 1'b0;
            csum_q        <= 8'h00;
            n_q           <= 4'd0;
            rem_q         <= 4'd0;
        end else begin
            tx_new_data_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (pop_s) begin
                rem_q <= rem_q - 4'd1;
            end
            if (state_q == IDLE) begin
                if (count_s >= CW'(FRAME_LEN)) begin
                    n_q     <= 4'(FRAME_LEN);
                    rem_q   <= 4'(FRAME_LEN);
                    csum_q  <= 8'h00;
                    busy_q  <= 1'b1;
                    state_q <= HDR;
                end else if (bus.flush && (count_s != {CW{1'b0}})) begin
                    // Partial frame: length is whatever is buffered right now.
                    n_q     <= 4'(count_s);
                    rem_q   <= 4'(count_s);
                    csum_q  <= 8'h00;
                    busy_q  <= 1'b1;
                    state_q <= HDR;
                end else begin
                    state_q <= IDLE;
                end
            end else if (!sent_q) begin
                if (!bus.tx_busy) begin
                    tx_new_data_q <= 1'b1;
                    tx_data_q     <= byte_s;
                    wait_q        <= 1'b1;
                    sent_q        <= 1'b1;
                    if (state_q == LEN) begin
                        csum_q <= byte_s;
                    end else if ((state_q == DATA_HI) || (state_q == DATA_LO)) begin
                        csum_q <= csum_q ^ byte_s;
                    end else begin
                        csum_q <= csum_q;
                    end
                end
            end else if (wait_q) begin
                if (bus.tx_busy) begin
                    wait_q <= 1'b0;
                end
            end else if (!bus.tx_busy) begin
                sent_q  <= 1'b0;
                state_q <= next_state_s;
                if (state_q == CSUM) begin
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                end
            end else begin
                state_q <= state_q;
            end
        end
    end
endmodule

// File: tb/tb_sample_packetizer.sv
module tb_sample_packetizer;

    typedef struct packed {
        int              n;
        logic            flush;
        logic [7:0]      csum;
        logic [3:0][15:0] w;
    } vec_t;

    logic clk;
    logic rst;
    sample_packetizer_if bus ();

    sample_packetizer #(
        .FRAME_LEN  (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          uart_mode = 0;   // 0 = random-latency UART, 1 = busy held high, 2 = manual
    bit          manual_busy = 1'b0;
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    logic [15:0] words_m [$];
    vec_t        vecs [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // UART model and output monitor.
    initial begin : uart_model
        int  busy_cnt;
        bit  prev_strobe;
        busy_cnt    = 0;
        prev_strobe = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) done_cnt++;
            if (bus.tx_new_data === 1'b1) begin
                check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
                got.push_back(bus.tx_data);
            end
            prev_strobe = (bus.tx_new_data === 1'b1);
            case (uart_mode)
                0: begin
                    if (bus.tx_new_data === 1'b1) begin
                        busy_cnt    = $urandom_range(1, 3);
                        bus.tx_busy = 1'b1;
                    end else if (busy_cnt > 0) begin
                        busy_cnt--;
                        if (busy_cnt == 0) bus.tx_busy = 1'b0;
                    end else begin
                        bus.tx_busy = 1'b0;
                    end
                end
                1: begin
                    busy_cnt    = 0;
                    bus.tx_busy = 1'b1;
                end
                default: begin
                    busy_cnt    = 0;
                    bus.tx_busy = manual_busy;
                end
            endcase
        end
    end

    task automatic push_word(input logic [15:0] w);
        int b;
        b = 0;
        while (bus.in_ready !== 1'b1 && b < 300) begin
            tick();
            b++;
        end
        check("push_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        words_m.push_back(w);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int b;
        b = 0;
        while (done_cnt < target && b < 3000) begin
            tick();
            b++;
        end
        check("frame_done_seen", {31'd0, done_cnt >= target}, 32'd1);
        repeat (4) tick();
        check("frame_done_count", done_cnt, target);
    endtask

    // Reference frame built from the frame format rules.
    task automatic model_frame(input int n);
        logic [7:0]  x;
        logic [15:0] w;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        x = 8'(n);
        for (int k = 0; k < n; k++) begin
            w = words_m.pop_front();
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        exp_q.push_back(x);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, exp_q[i]});
        end
        got.delete();
        exp_q.delete();
    endtask

    function automatic vec_t mk(input int n, input logic fl, input logic [7:0] cs,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        vec_t v;
        v.n     = n;
        v.flush = fl;
        v.csum  = cs;
        v.w[0]  = a;
        v.w[1]  = b;
        v.w[2]  = c;
        v.w[3]  = d;
        return v;
    endfunction

    initial begin : main
        int base;
        vecs[0] = mk(4, 1'b0, 8'h04, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        vecs[1] = mk(1, 1'b1, 8'hFE, 16'h00FF, 16'h0000, 16'h0000, 16'h0000);
        vecs[2] = mk(2, 1'b1, 8'h02, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);
        vecs[3] = mk(3, 1'b1, 8'h0A, 16'h0102, 16'h0304, 16'h0508, 16'h0000);
        vecs[4] = mk(4, 1'b0, 8'h04, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        rst          = 1'b1;
        bus.in_data  = 16'h0000;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_tx_new_data", {31'd0, bus.tx_new_data}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Table of full and flushed frames.
        for (int i = 0; i < 5; i++) begin
            base = done_cnt;
            for (int k = 0; k < vecs[i].n; k++) push_word(vecs[i].w[k]);
            if (vecs[i].flush) pulse_flush();
            wait_frames(base + 1);
            check("vec_csum", (got.size() > 0) ? {24'd0, got[got.size()-1]} : 32'hDEAD,
                  {24'd0, vecs[i].csum});
            model_frame(vecs[i].n);
            compare_stream("vec_bytes");
            check("vec_idle", {31'd0, bus.busy}, 32'd0);
        end

        // Flush with an empty FIFO sends nothing.
        pulse_flush();
        repeat (20) tick();
        check("empty_flush_bytes", got.size(), 0);
        check("empty_flush_busy", {31'd0, bus.busy}, 32'd0);

        // UART held busy: FIFO fills to 8, the 9th word is held off.
        base      = done_cnt;
        uart_mode = 1;
        repeat (2) tick();
        for (int k = 0; k < 8; k++) push_word(16'($urandom));
        repeat (2) tick();
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_data  = 16'hBEEF;
        bus.in_valid = 1'b1;
        repeat (6) tick();
        bus.in_valid = 1'b0;
        check("full_still_blocked", {31'd0, bus.in_ready}, 32'd0);
        check("full_no_strobe", got.size(), 0);
        check("full_busy", {31'd0, bus.busy}, 32'd1);
        // Release the UART and keep feeding while the FIFO drains.
        uart_mode = 0;
        for (int k = 0; k < 4; k++) push_word(16'($urandom));
        wait_frames(base + 3);
        for (int f = 0; f < 3; f++) model_frame(4);
        compare_stream("drain_bytes");

        // Randomised traffic in whole frames with random gaps.
        base = done_cnt;
        for (int k = 0; k < 12; k++) begin
            push_word(16'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_frames(base + 3);
        for (int f = 0; f < 3; f++) model_frame(4);
        compare_stream("rand_bytes");

        // Reset while the first DATA_HI byte is on the wire.
        for (int k = 0; k < 4; k++) push_word(16'($urandom));
        begin
            int b;
            b = 0;
            while (got.size() < 3 && b < 300) begin
                tick();
                b++;
            end
        end
        check("rst_mid_reached", {31'd0, got.size() >= 3}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mid_strobe", {31'd0, bus.tx_new_data}, 32'd0);
        rst = 1'b0;
        got.delete();
        words_m.delete();
        repeat (30) tick();
        check("rst_mid_no_bytes", got.size(), 0);

        // tx_busy stuck low: a single strobe until busy is seen high then low.
        uart_mode   = 2;
        manual_busy = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) push_word(16'h0102);
        repeat (30) tick();
        check("stuck_one_strobe", got.size(), 1);
        check("stuck_first_byte", (got.size() > 0) ? {24'd0, got[0]} : 32'hDEAD, 32'hA5);
        manual_busy = 1'b1;
        tick();
        manual_busy = 1'b0;
        repeat (10) tick();
        check("stuck_two_strobes", got.size(), 2);
        check("stuck_len_byte", (got.size() > 1) ? {24'd0, got[1]} : 32'hDEAD, 32'h04);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_mode = 0;
        got.delete();
        words_m.delete();
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
